mac_dot_seq: RTL and testbench

Upstream sequencer for `mac_top`: accepts a stream of signed 16-bit operand pairs grouped into vectors, and drives the MAC's `start`/`clr_acc`/`A_in`/`B_in` handshake one pair at a time. Each vector ends with the `s_last` pair. After the last product is accumulated, the block captures the MAC's 40-bit `Accumulator` as a dot-product result and offers it on a valid/ready output. Operands are buffered in a small FIFO so the producer is decoupled from MAC latency.

---
 rtl/mac_pkg.sv | 27 ++
 rtl/mac_seq_fifo.sv | 58 +++++
 rtl/mac_dot_seq.sv | 179 +++++++++++++++++
 tb/tb_mac_dot_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types for the MAC dot-product sequencer: accumulator width,
// sequencer FSM states and the packed operand-pair FIFO entry.
package mac_pkg;

  localparam int ACC_WIDTH  = 40;
  localparam int OPND_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    ISSUE,
    WAIT,
    SETTLE,
    DONE,
    DRAIN
  } dotseq_state_t;

  typedef struct packed {
    logic                  last;
    logic [OPND_WIDTH-1:0] a;
    logic [OPND_WIDTH-1:0] b;
  } dotseq_entry_t;

  localparam int ENTRY_W = $bits(dotseq_entry_t);

endpackage

// File: rtl/mac_seq_fifo.sv
// Synchronous operand-pair FIFO with full/empty flags; pointers carry an
// extra wrap bit so full and empty are distinguishable without a counter.
module mac_seq_fifo
  import mac_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic               full,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (rd_en && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer driving mac_top one operand pair at a time.
// Optional WAIT-state watchdog enabled by defining MAC_DOTSEQ_TIMEOUT_EN.
module mac_dot_seq
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ACC_WIDTH      = mac_pkg::ACC_WIDTH,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_a,
  input  logic [DATA_WIDTH-1:0] s_b,
  input  logic                  s_last,
  output logic                  mac_start,
  output logic                  mac_clr_acc,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  input  logic [ACC_WIDTH-1:0]  mac_acc,
  input  logic                  mac_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic [CNT_WIDTH-1:0]  res_count,
  output logic                  res_err
);

  dotseq_state_t         state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] mac_a_q, mac_a_d;
  logic [DATA_WIDTH-1:0] mac_b_q, mac_b_d;
  logic [ACC_WIDTH-1:0]  res_data_q, res_data_d;
  logic [CNT_WIDTH-1:0]  res_count_q, res_count_d;

  dotseq_entry_t      wr_entry, rd_entry;
  logic [ENTRY_W-1:0] rd_word;
  logic               fifo_full, fifo_empty, fifo_pop;

  assign wr_entry = '{last: s_last, a: s_a, b: s_b};
  assign rd_entry = dotseq_entry_t'(rd_word);
  assign s_ready  = !fifo_full;

  mac_seq_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (s_valid),
    .wr_data(wr_entry),
    .full   (fifo_full),
    .rd_en  (fifo_pop),
    .rd_data(rd_word),
    .empty  (fifo_empty)
  );

`ifdef MAC_DOTSEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            res_err_q, res_err_d;
  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  assign mac_start   = (state_q == ISSUE);
  assign mac_clr_acc = (state_q == CLEAR);
  assign res_valid   = (state_q == DONE);
  assign mac_a       = mac_a_q;
  assign mac_b       = mac_b_q;
  assign res_data    = res_data_q;
  assign res_count   = res_count_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;
    fifo_pop    = 1'b0;
`ifdef MAC_DOTSEQ_TIMEOUT_EN
    wdog_d      = wdog_q;
    res_err_d   = res_err_q;
`endif
    case (state_q)
      IDLE:  if (!fifo_empty) state_d = CLEAR;
      CLEAR: begin
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        mac_a_d  = rd_entry.a;
        mac_b_d  = rd_entry.b;
        last_d   = rd_entry.last;
        cnt_d    = cnt_q + CNT_WIDTH'(1);
        state_d  = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef MAC_DOTSEQ_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      WAIT: begin
        if (mac_ready) begin
          state_d = SETTLE;
`ifdef MAC_DOTSEQ_TIMEOUT_EN
        end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          // Abort: report what was consumed, then discard the vector's tail.
          res_err_d   = 1'b1;
          res_data_d  = '0;
          res_count_d = cnt_q;
          state_d     = last_q ? DONE : DRAIN;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
`endif
        end
      end
`ifdef MAC_DOTSEQ_TIMEOUT_EN
      DRAIN: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        if (rd_entry.last) state_d = DONE;
      end
`endif
      SETTLE: begin
        if (last_q) begin
          res_data_d  = mac_acc;
          res_count_d = cnt_q;
`ifdef MAC_DOTSEQ_TIMEOUT_EN
          res_err_d   = 1'b0;
`endif
          state_d     = DONE;
        end else begin
          state_d = LOAD;
        end
      end
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_data_q  <= '0;
      res_count_q <= '0;
`ifdef MAC_DOTSEQ_TIMEOUT_EN
      wdog_q      <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
`ifdef MAC_DOTSEQ_TIMEOUT_EN
      wdog_q      <= wdog_d;
      res_err_q   <= res_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Scoreboard bench for mac_dot_seq with a behavioural MAC model attached.
module tb_mac_dot_seq;
  localparam int DW = 16;
  localparam int AW = 40;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0, s_last = 1'b0, res_ready = 1'b1;
  logic [DW-1:0] s_a = '0, s_b = '0;
  logic          s_ready, mac_start, mac_clr_acc, res_valid, res_err;
  logic [DW-1:0] mac_a, mac_b;
  logic [AW-1:0] res_data;
  logic [CW-1:0] res_count;

  typedef struct {
    logic [AW-1:0] data;
    logic [CW-1:0] cnt;
    logic          err;
  } res_t;

  res_t exp_q[$];
  res_t obs_mem[64];
  int   obs_wr = 0, obs_rd = 0;
  int   n_cmp = 0, n_fail = 0;
  int   clr_cnt = 0, overlap_viol = 0, dstart_viol = 0;
  bit   start_out = 1'b0;

  // MAC model: product lands in the accumulator together with ready.
  logic signed [AW-1:0] m_acc = '0;
  logic                 m_ready = 1'b0;
  logic signed [31:0]   m_prod;
  int                   m_dly = 0;
  int                   mac_latency = 3;
  bit                   mac_never = 1'b0;

  assign m_prod = $signed(mac_a) * $signed(mac_b);

  always #5 clk = ~clk;

  mac_dot_seq #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .FIFO_DEPTH(4), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .s_last(s_last), .mac_start(mac_start), .mac_clr_acc(mac_clr_acc), .mac_a(mac_a),
    .mac_b(mac_b), .mac_acc(m_acc), .mac_ready(m_ready), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_count(res_count), .res_err(res_err)
  );

  always @(posedge clk) begin
    m_ready <= 1'b0;
    if (mac_clr_acc) m_acc <= '0;
    if (mac_start) m_dly <= mac_latency;
    else if (m_dly > 0) begin
      m_dly <= m_dly - 1;
      if (m_dly == 1 && !mac_never) begin
        m_ready <= 1'b1;
        m_acc   <= m_acc + {{8{m_prod[31]}}, m_prod};
      end
    end
  end

  always @(negedge clk) begin
    if (rst) start_out <= 1'b0;
    else begin
      if (mac_clr_acc) clr_cnt <= clr_cnt + 1;
      if (mac_start && mac_clr_acc) overlap_viol <= overlap_viol + 1;
      if (mac_start) begin
        if (start_out) dstart_viol <= dstart_viol + 1;
        start_out <= 1'b1;
      end else if (m_ready || res_valid) start_out <= 1'b0;
      if (res_valid && res_ready) begin
        obs_mem[obs_wr % 64] <= '{res_data, res_count, res_err};
        obs_wr <= obs_wr + 1;
      end
    end
  end

  task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
    bit ok = 1'b0;
    s_a = a; s_b = b; s_last = last; s_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); ok = s_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    s_valid = 1'b0; s_last = 1'b0;
    n_cmp++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL push_accept: pair %0d,%0d never accepted", a, b); end
  endtask

  task automatic push_exp(input logic [AW-1:0] d, input logic [CW-1:0] c, input logic e);
    res_t r;
    r.data = d; r.cnt = c; r.err = e;
    exp_q.push_back(r);
  endtask

  task automatic get_result(output res_t r, output bit got);
    got = 1'b0;
    r   = '{'0, '0, 1'b0};
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (obs_rd < obs_wr) begin
        r = obs_mem[obs_rd % 64]; obs_rd++; got = 1'b1; break;
      end
    end
  endtask

  task automatic check_result(input string tag);
    res_t o, e;
    bit   got;
    get_result(o, got);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL %s_timeout: no result, want data=%h", tag, e.data); return; end
    n_cmp++;
    if (o.data !== e.data) begin n_fail++; $display("FAIL %s_data: got %h want %h", tag, o.data, e.data); end
    n_cmp++;
    if (o.cnt !== e.cnt) begin n_fail++; $display("FAIL %s_count: got %0d want %0d", tag, o.cnt, e.cnt); end
    n_cmp++;
    if (o.err !== e.err) begin n_fail++; $display("FAIL %s_err: got %0b want %0b", tag, o.err, e.err); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({s_ready, mac_start, mac_clr_acc, res_valid, res_err} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 10000", {s_ready, mac_start, mac_clr_acc, res_valid, res_err});
    end
    n_cmp++;
    if ({mac_a, mac_b} !== '0) begin n_fail++; $display("FAIL reset_operands: got %h want 0", {mac_a, mac_b}); end
    n_cmp++;
    if ({res_data, res_count} !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", {res_data, res_count}); end
    @(posedge clk); #1;
  endtask

  task automatic test_vector();
    int c0 = clr_cnt;
    res_ready = 1'b1;
    push_exp(40'd1044, 16'd3, 1'b0);
    push_pair(16'd10, 16'd5, 1'b0);
    push_pair(16'd2, -16'sd3, 1'b0);
    push_pair(16'd100, 16'd10, 1'b1);
    check_result("vector");
    n_cmp++;
    if (clr_cnt - c0 !== 1) begin n_fail++; $display("FAIL vector_clr: got %0d pulses want 1", clr_cnt - c0); end
  endtask

  task automatic test_single();
    push_exp(40'hFF_FFFF_FFD6, 16'd1, 1'b0);
    push_pair(-16'sd7, 16'd6, 1'b1);
    check_result("single");
  endtask

  task automatic test_back_to_back();
    int c0 = clr_cnt;
    push_exp(40'd9, 16'd1, 1'b0);
    push_exp(40'd16, 16'd1, 1'b0);
    push_pair(16'd3, 16'd3, 1'b1);
    push_pair(16'd4, 16'd4, 1'b1);
    check_result("b2b_first");
    check_result("b2b_second");
    n_cmp++;
    if (clr_cnt - c0 !== 2) begin n_fail++; $display("FAIL b2b_clr: got %0d pulses want 2", clr_cnt - c0); end
  endtask

  task automatic test_backpressure();
    int  bad = 0;
    bit  seen = 1'b0;
    res_ready = 1'b0;
    push_exp(40'd25, 16'd1, 1'b0);
    push_exp(40'd55, 16'd5, 1'b0);
    push_pair(16'd5, 16'd5, 1'b1);
    for (int i = 0; i < 100 && !seen; i++) begin @(negedge clk); seen = res_valid; end
    @(posedge clk); #1;
    n_cmp++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL bp_valid: res_valid got 0 want 1"); end
    for (int k = 1; k <= 4; k++) push_pair(DW'(k), DW'(k), 1'b0);
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: s_ready got %b want 0", s_ready); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== 40'd25) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: %0d unstable cycles want 0", bad); end
    @(posedge clk); #1;
    res_ready = 1'b1;
    push_pair(16'd5, 16'd5, 1'b1);
    check_result("bp_first");
    check_result("bp_second");
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    int c0, w0;
    mac_latency = 40;
    push_pair(16'd7, 16'd7, 1'b0);
    push_pair(16'd8, 16'd8, 1'b1);
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = mac_start; end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({s_ready, mac_start, mac_clr_acc, res_valid, res_err} !== 5'b10000) begin
      n_fail++; $display("FAIL rstmid_ctrl: got %b want 10000", {s_ready, mac_start, mac_clr_acc, res_valid, res_err});
    end
    n_cmp++;
    if ({mac_a, mac_b, res_data, res_count} !== '0) begin
      n_fail++; $display("FAIL rstmid_data: got %h want 0", {mac_a, mac_b, res_data, res_count});
    end
    c0 = clr_cnt; w0 = obs_wr;
    repeat (60) @(negedge clk);
    n_cmp++;
    if (clr_cnt !== c0 || obs_wr !== w0) begin
      n_fail++; $display("FAIL rstmid_flush: clr %0d results %0d after reset want 0 0", clr_cnt - c0, obs_wr - w0);
    end
    mac_latency = 3;
    @(posedge clk); #1;
  endtask

`ifdef MAC_DOTSEQ_TIMEOUT_EN
  task automatic test_timeout();
    mac_never = 1'b1;
    push_exp(40'd0, 16'd1, 1'b1);
    push_pair(16'd1, 16'd1, 1'b0);
    push_pair(16'd2, 16'd2, 1'b0);
    push_pair(16'd3, 16'd3, 1'b1);
    check_result("timeout");
    mac_never = 1'b0;
    push_exp(40'd6, 16'd1, 1'b0);
    push_pair(16'd2, 16'd3, 1'b1);
    check_result("after_timeout");
  endtask
`endif

  task automatic test_protocol();
    n_cmp++;
    if (overlap_viol !== 0) begin n_fail++; $display("FAIL proto_overlap: got %0d want 0", overlap_viol); end
    n_cmp++;
    if (dstart_viol !== 0) begin n_fail++; $display("FAIL proto_double_start: got %0d want 0", dstart_viol); end
  endtask

  initial begin
    test_reset();
    test_vector();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef MAC_DOTSEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
